// File: rtl/gfsk_demodulation_if.sv
// gfsk_demodulation_if: I/Q sample input and demodulated bit output bundle for the GFSK demodulator.
interface gfsk_demodulation_if #(
  parameter int SAMPLE_PER_SYMBOL = 8,
  parameter int IQ_BIT_WIDTH = 8
);
  logic [$clog2(SAMPLE_PER_SYMBOL)-1:0] sample_phase;
  logic signed [IQ_BIT_WIDTH-1:0] i_in;
  logic signed [IQ_BIT_WIDTH-1:0] q_in;
  logic iq_valid;
  logic iq_valid_last;
  logic iq_ready;
  logic signed [2*IQ_BIT_WIDTH:0] disc_out;
  logic disc_valid;
  logic phy_bit;
  logic bit_valid;
  logic bit_valid_last;
  modport master (
    output sample_phase, i_in, q_in, iq_valid, iq_valid_last,
    input iq_ready, disc_out, disc_valid, phy_bit, bit_valid, bit_valid_last
  );
  modport slave (
    input sample_phase, i_in, q_in, iq_valid, iq_valid_last,
    output iq_ready, disc_out, disc_valid, phy_bit, bit_valid, bit_valid_last
  );
endinterface

// File: rtl/gfsk_demodulation.sv
// gfsk_demodulation: delay-conjugate FM discriminator with per-symbol slicer and one-bit hold,
// so the final bit of a burst can be flagged with bit_valid_last.
module gfsk_demodulation #(
  parameter int SAMPLE_PER_SYMBOL = 8,
  parameter int IQ_BIT_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  gfsk_demodulation_if.slave bus
);
  localparam int CW = $clog2(SAMPLE_PER_SYMBOL);
  localparam int W = IQ_BIT_WIDTH;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, FLUSH} state_t;
  state_t state_q, state_d;
  logic rdy_q, rdy_d;
  logic [CW-1:0] cnt_q, cnt_d, phase_q, phase_d, idx0_q, idx0_d, idx1_q, idx1_d, idx2_q, idx2_d;
  logic signed [W-1:0] ci_q, ci_d, cq_q, cq_d, pi_q, pi_d, pq_q, pq_d;
  logic v0_q, v0_d, l0_q, l0_d, v1_q, v1_d, l1_q, l1_d, v2_q, v2_d, l2_q, l2_d;
  logic signed [2*W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic signed [2*W:0] disc_q, disc_d;
  logic pend_q, pend_d, pv_q, pv_d, bit_q, bit_d, bv_q, bv_d, bl_q, bl_d;
  logic acc, dec, start;
  always_comb begin
    acc = bus.iq_valid && rdy_q;
    start = state_q == IDLE;
    dec = v2_q && (idx2_q == phase_q);
    state_d = state_q;
    rdy_d = rdy_q;
    cnt_d = cnt_q;
    phase_d = phase_q;
    ci_d = ci_q;
    cq_d = cq_q;
    pi_d = pi_q;
    pq_d = pq_q;
    idx0_d = idx0_q;
    v0_d = acc;
    l0_d = bus.iq_valid_last;
    v1_d = v0_q;
    l1_d = l0_q;
    idx1_d = idx0_q;
    p1_d = pi_q * cq_q;
    p2_d = pq_q * ci_q;
    v2_d = v1_q;
    l2_d = l1_q;
    idx2_d = idx1_q;
    disc_d = {p1_q[2*W-1], p1_q} - {p2_q[2*W-1], p2_q};
    pend_d = pend_q;
    pv_d = pv_q;
    bit_d = bit_q;
    bv_d = 1'b0;
    bl_d = 1'b0;
    if (acc) begin
      ci_d = bus.i_in;
      cq_d = bus.q_in;
      pi_d = start ? '0 : ci_q;
      pq_d = start ? '0 : cq_q;
      idx0_d = start ? '0 : cnt_q;
      cnt_d = idx0_d + 1'b1;
      phase_d = start ? bus.sample_phase : phase_q;
      state_d = bus.iq_valid_last ? DRAIN : ACTIVE;
      rdy_d = !bus.iq_valid_last;
    end
    // the previous symbol's bit leaves only when the next decision proves it is not the last
    if (dec) begin
      bit_d = pv_q ? pend_q : bit_q;
      bv_d = pv_q;
      pend_d = !disc_q[2*W] && |disc_q;
      pv_d = 1'b1;
    end
    if (state_q == DRAIN && v2_q && l2_q) state_d = FLUSH;
    if (state_q == FLUSH) begin
      state_d = IDLE;
      rdy_d = 1'b1;
      bit_d = pv_q ? pend_q : bit_q;
      bv_d = pv_q;
      bl_d = pv_q;
      pv_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q <= 1'b1;
      cnt_q <= '0;
      phase_q <= '0;
      ci_q <= '0;
      cq_q <= '0;
      pi_q <= '0;
      pq_q <= '0;
      idx0_q <= '0;
      idx1_q <= '0;
      idx2_q <= '0;
      v0_q <= 1'b0;
      l0_q <= 1'b0;
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      v2_q <= 1'b0;
      l2_q <= 1'b0;
      p1_q <= '0;
      p2_q <= '0;
      disc_q <= '0;
      pend_q <= 1'b0;
      pv_q <= 1'b0;
      bit_q <= 1'b0;
      bv_q <= 1'b0;
      bl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q <= rdy_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      ci_q <= ci_d;
      cq_q <= cq_d;
      pi_q <= pi_d;
      pq_q <= pq_d;
      idx0_q <= idx0_d;
      idx1_q <= idx1_d;
      idx2_q <= idx2_d;
      v0_q <= v0_d;
      l0_q <= l0_d;
      v1_q <= v1_d;
      l1_q <= l1_d;
      v2_q <= v2_d;
      l2_q <= l2_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      disc_q <= disc_d;
      pend_q <= pend_d;
      pv_q <= pv_d;
      bit_q <= bit_d;
      bv_q <= bv_d;
      bl_q <= bl_d;
    end
  end
  assign bus.iq_ready = rdy_q;
  assign bus.disc_out = disc_q;
  assign bus.disc_valid = v2_q;
  assign bus.phy_bit = bit_q;
  assign bus.bit_valid = bv_q;
  assign bus.bit_valid_last = bl_q;
endmodule

// File: tb/tb_gfsk_demodulation.sv
// tb_gfsk_demodulation: scoreboard bench; stimulus pushes expected disc/bit values, a negedge monitor pops and compares.
module tb_gfsk_demodulation;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  int dq[$];
  logic [1:0] bq[$];
  int bits_seen, ones_seen, lasts_seen, last_disc;
  int m_pi, m_pq, m_idx, m_phase, m_pend, m_pv, m_first;
  int C[16] = '{100, 92, 71, 38, 0, -38, -71, -92, -100, -92, -71, -38, 0, 38, 71, 92};
  gfsk_demodulation_if #(.SAMPLE_PER_SYMBOL(8), .IQ_BIT_WIDTH(8)) bus ();
  gfsk_demodulation #(.SAMPLE_PER_SYMBOL(8), .IQ_BIT_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", n, a, e);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (bus.disc_valid) begin
      last_disc = int'(bus.disc_out);
      if (dq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL disc_extra actual=%0d expected=none", bus.disc_out);
      end else chk("disc_out", bus.disc_out, dq.pop_front());
    end
    if (bus.bit_valid) begin
      bits_seen++;
      ones_seen += int'(bus.phy_bit);
      lasts_seen += int'(bus.bit_valid_last);
      if (bq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bit_extra actual=%0d expected=none", {bus.phy_bit, bus.bit_valid_last});
      end else chk("bit_last", {bus.phy_bit, bus.bit_valid_last}, bq.pop_front());
    end
  end
  task automatic send(input int i, input int q, input bit last);
    int t = 0;
    int d;
    @(negedge clk);
    while (!bus.iq_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("ready_timeout", t, 0);
    bus.i_in = 8'(i);
    bus.q_in = 8'(q);
    bus.iq_valid = 1'b1;
    bus.iq_valid_last = last;
    if (m_first != 0) begin
      m_pi = 0;
      m_pq = 0;
      m_idx = 0;
      m_phase = int'(bus.sample_phase);
    end
    m_first = 0;
    d = m_pi * q - m_pq * i;
    dq.push_back(d);
    if (m_idx == m_phase) begin
      if (m_pv != 0) bq.push_back({m_pend[0], 1'b0});
      m_pend = (d > 0) ? 1 : 0;
      m_pv = 1;
    end
    m_pi = i;
    m_pq = q;
    m_idx = (m_idx + 1) % 8;
    if (last) begin
      if (m_pv != 0) bq.push_back({m_pend[0], 1'b1});
      m_pv = 0;
      m_first = 1;
    end
  endtask
  task automatic finish_burst(input int exp_low);
    int n = 0;
    @(negedge clk);
    bus.iq_valid = 1'b0;
    bus.iq_valid_last = 1'b0;
    while (!bus.iq_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("ready_low_cycles", n, exp_low);
    @(negedge clk);
  endtask
  task automatic tone(input bit cw, input int n, input int phase, input bit hold);
    bus.sample_phase = 3'(phase);
    for (int k = 0; k < n; k++) send(C[k % 16], cw ? -C[(k + 12) % 16] : C[(k + 12) % 16], k == n - 1);
    if (!hold) finish_burst(4);
  endtask
  task automatic clear_counts();
    bits_seen = 0;
    ones_seen = 0;
    lasts_seen = 0;
  endtask
  initial begin
    m_first = 1;
    m_pv = 0;
    m_pend = 0;
    last_disc = 0;
    clear_counts();
    bus.sample_phase = 3'd4;
    bus.i_in = '0;
    bus.q_in = '0;
    bus.iq_valid = 1'b0;
    bus.iq_valid_last = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_iq_ready", bus.iq_ready, 1);
    chk("rst_disc_out", bus.disc_out, 0);
    chk("rst_disc_valid", bus.disc_valid, 0);
    chk("rst_bits", {bus.phy_bit, bus.bit_valid, bus.bit_valid_last}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tone(1'b0, 32, 4, 1'b0);
    chk("ccw_bits", bits_seen, 4);
    chk("ccw_ones", ones_seen, 4);
    chk("ccw_lasts", lasts_seen, 1);
    clear_counts();
    tone(1'b1, 32, 4, 1'b0);
    chk("cw_bits", bits_seen, 4);
    chk("cw_ones", ones_seen, 0);
    chk("cw_lasts", lasts_seen, 1);
    bus.sample_phase = 3'd4;
    send(127, 0, 1'b0);
    send(0, 127, 1'b1);
    finish_burst(4);
    chk("arith_16129", last_disc, 16129);
    send(-128, -128, 1'b0);
    send(127, -128, 1'b1);
    finish_burst(4);
    chk("arith_32640", last_disc, 32640);
    clear_counts();
    tone(1'b0, 3, 4, 1'b0);
    chk("short_bits", bits_seen, 0);
    chk("short_lasts", lasts_seen, 0);
    clear_counts();
    tone(1'b0, 16, 4, 1'b1);
    tone(1'b0, 16, 4, 1'b0);
    chk("b2b_bits", bits_seen, 4);
    chk("b2b_lasts", lasts_seen, 2);
    bus.sample_phase = 3'd4;
    for (int k = 0; k < 10; k++) send(C[k % 16], C[(k + 12) % 16], 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.iq_valid = 1'b0;
    dq.delete();
    bq.delete();
    m_first = 1;
    m_pv = 0;
    #1;
    chk("mid_rst_iq_ready", bus.iq_ready, 1);
    chk("mid_rst_disc", {bus.disc_valid, bus.disc_out}, 0);
    chk("mid_rst_bits", {bus.phy_bit, bus.bit_valid, bus.bit_valid_last}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    tone(1'b0, 9, 0, 1'b0);
    chk("post_rst_bits", bits_seen, 2);
    chk("post_rst_ones", ones_seen, 1);
    repeat (10) @(negedge clk);
    chk("disc_queue_empty", dq.size(), 0);
    chk("bit_queue_empty", bq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
